// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared LUT sizing constants and configuration types
package fpga_cfg_pkg;
  localparam int LUT_K = 4;
  localparam int LUT_SIZE = 16;
  typedef logic [LUT_SIZE-1:0] lut_cfg_t;
endpackage

// File: rtl/fpga_mux16.sv
// fpga_mux16: combinational 16:1 mux built as a tree of 2:1 muxes, sel[0] at the leaves
module fpga_mux16 (
  input  logic [15:0] data,
  input  logic [3:0]  sel,
  output logic        y
);
  logic [7:0] l1;
  logic [3:0] l2;
  logic [1:0] l3;
  for (genvar i = 0; i < 8; i++) begin : g_l1
    assign l1[i] = sel[0] ? data[2*i+1] : data[2*i];
  end
  for (genvar i = 0; i < 4; i++) begin : g_l2
    assign l2[i] = sel[1] ? l1[2*i+1] : l1[2*i];
  end
  for (genvar i = 0; i < 2; i++) begin : g_l3
    assign l3[i] = sel[2] ? l2[2*i+1] : l2[2*i];
  end
  assign y = sel[3] ? l3[1] : l3[0];
endmodule

// File: rtl/fpga_4lut_cell.sv
// fpga_4lut_cell: 4-input LUT with a clocked truth-table register and combinational readout
module fpga_4lut_cell
  import fpga_cfg_pkg::*;
#(
  parameter lut_cfg_t RESET_CONFIG = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] config_i,
  input  logic        config_we_i,
  input  logic        i0_i,
  input  logic        i1_i,
  input  logic        i2_i,
  input  logic        i3_i,
  output logic        lut_o
);
  lut_cfg_t cfg_q;
  logic [LUT_K-1:0] sel;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cfg_q <= RESET_CONFIG;
    else if (config_we_i) cfg_q <= config_i;
  assign sel = {i0_i, i1_i, i2_i, i3_i};
  fpga_mux16 u_mux (
    .data (cfg_q),
    .sel  (sel),
    .y    (lut_o)
  );
endmodule

// File: tb/tb_fpga_4lut_cell.sv
// tb_fpga_4lut_cell: table-driven, directed and randomized checks against a shift-based LUT model
`timescale 1ns/1ps
module tb_fpga_4lut_cell;
  logic clk, rst_n, we, i0, i1, i2, i3, lut;
  logic [15:0] cfg_in;
  logic [15:0] model;
  int n_pass = 0, n_total = 0;

  typedef struct {
    logic [15:0] cfg;
    logic [3:0]  sel;
    logic        exp;
  } vec_t;
  vec_t vecs[32];

  fpga_4lut_cell dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .config_i    (cfg_in),
    .config_we_i (we),
    .i0_i        (i0),
    .i1_i        (i1),
    .i2_i        (i2),
    .i3_i        (i3),
    .lut_o       (lut)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic ref_out(input logic [15:0] table_v, input logic [3:0] s);
    return 1'((table_v >> s) & 16'd1);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_sel(input logic [3:0] s);
    {i0, i1, i2, i3} = s;
  endtask

  // one-cycle write pulse, then scramble config_i to show it is ignored while we is low
  task automatic load(input logic [15:0] v);
    @(negedge clk);
    cfg_in = v;
    we = 1;
    @(negedge clk);
    we = 0;
    cfg_in = 16'($urandom);
    model = v;
  endtask

  initial begin
    logic exp_f0[16] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1};
    logic exp_ab[16] = '{1,0,1,1,0,0,1,1,1,1,0,1,0,1,0,1};
    for (int k = 0; k < 16; k++) begin
      vecs[k]    = '{16'hF0F0, 4'(k), exp_f0[k]};
      vecs[16+k] = '{16'hABCD, 4'(k), exp_ab[k]};
    end
    rst_n = 1; we = 0; cfg_in = 0; model = 0;
    set_sel(0);
    #1 rst_n = 0;
    for (int k = 0; k < 16; k++) begin
      set_sel(4'(k));
      #0.2 check("reset_sweep", lut, 1'b0);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    set_sel(4'hF); #0.2 check("after_release", lut, 1'b0);
    set_sel(4'h5); #0.2 check("after_release", lut, 1'b0);

    for (int k = 0; k < 32; k++) begin
      if (vecs[k].cfg !== model) load(vecs[k].cfg);
      set_sel(vecs[k].sel);
      #0.2 check(k < 16 ? "tbl_f0f0" : "tbl_abcd", lut, vecs[k].exp);
    end

    @(negedge clk);
    we = 1; cfg_in = 16'h0001;
    @(negedge clk) cfg_in = 16'h0002;
    @(negedge clk) cfg_in = 16'h8000;
    @(negedge clk) we = 0;
    model = 16'h8000;
    set_sel(4'hF); #0.2 check("burst_selF", lut, 1'b1);
    set_sel(4'h0); #0.2 check("burst_sel0", lut, 1'b0);
    set_sel(4'h1); #0.2 check("burst_sel1", lut, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) cfg_in = ~cfg_in;
    end
    @(negedge clk);
    set_sel(4'hF); #0.2 check("hold_selF", lut, 1'b1);
    set_sel(4'h1); #0.2 check("hold_sel1", lut, 1'b0);

    load(16'hFFFF);
    set_sel(4'h6); #0.2 check("ffff_sel6", lut, 1'b1);
    @(negedge clk);
    #2 rst_n = 0;
    #0.5 check("async_reset", lut, 1'b0);
    set_sel(4'hA); #0.2 check("async_reset_selA", lut, 1'b0);
    @(negedge clk) rst_n = 1;
    model = 0;

    load(16'h0001);
    set_sel(4'h0); #0.2 check("oh1_sel0", lut, 1'b1);
    set_sel(4'hF); #0.2 check("oh1_selF", lut, 1'b0);
    set_sel(4'h8); #0.2 check("oh1_i0only", lut, 1'b0);
    load(16'h8000);
    set_sel(4'h0); #0.2 check("oh8000_sel0", lut, 1'b0);
    set_sel(4'hF); #0.2 check("oh8000_selF", lut, 1'b1);
    load(16'h0100);
    set_sel(4'h8); #0.2 check("i0_is_msb", lut, 1'b1);
    set_sel(4'h1); #0.2 check("i0_is_msb_neg", lut, 1'b0);
    load(16'h0002);
    set_sel(4'h1); #0.2 check("i3_is_lsb", lut, 1'b1);

    for (int k = 0; k < 300; k++) begin
      logic [3:0] s;
      logic [15:0] c;
      logic w;
      @(negedge clk);
      s = 4'($urandom); c = 16'($urandom); w = 1'($urandom_range(0, 2) == 0);
      cfg_in = c; we = w; set_sel(s);
      #0.2 check("rnd_pre_edge", lut, ref_out(model, s));
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 0;
        model = 0;
        #0.2 check("rnd_reset", lut, 1'b0);
        #0.5 rst_n = 1;
      end
      @(posedge clk);
      if (w) model = c;
      #1 check("rnd_post_edge", lut, ref_out(model, s));
      s = 4'($urandom); set_sel(s);
      #0.2 check("rnd_comb", lut, ref_out(model, s));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
